fp_divider_seq: RTL and testbench

FP_DIVIDER_SEQ -- requirements
Module: fp_divider_seq

---
 rtl/fp_divider_seq.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_fp_divider_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_divider_seq.sv
// ============================================================================
//  Module   : fp_divider_seq
//  Purpose  : Sequential IEEE-754 binary32 divider. Restoring radix-2
//             significand division, one quotient bit per clock, with
//             special-operand handling and flush-to-zero on underflow.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid / in_ready        - operand handshake (a_bits, b_bits)
//             out_valid / out_ready      - result handshake (out_bits,
//                                          except_flags)
//  Options  : FP_DIV_ROUND_NEAREST_EN defined   -> round to nearest even
//             FP_DIV_ROUND_NEAREST_EN undefined -> truncate (toward zero)
//  Flags    : except_flags bit positions given by F_INVALID,
//             F_DIVIDE_BY_ZERO, F_OVERFLOW, F_UNDERFLOW, F_INEXACT
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef F_INVALID
`define F_INVALID        4
`endif
`ifndef F_DIVIDE_BY_ZERO
`define F_DIVIDE_BY_ZERO 3
`endif
`ifndef F_OVERFLOW
`define F_OVERFLOW       2
`endif
`ifndef F_UNDERFLOW
`define F_UNDERFLOW      1
`endif
`ifndef F_INEXACT
`define F_INEXACT        0
`endif

module fp_divider_seq #(
   parameter int EXP  = 8,
   parameter int FRAC = 23,
   parameter int BIAS = 127
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [EXP+FRAC:0] a_bits,
   input  logic [EXP+FRAC:0] b_bits,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [EXP+FRAC:0] out_bits,
   output logic [4:0]        except_flags
);

   localparam int W  = EXP + FRAC + 1;   // word width
   localparam int SW = FRAC + 1;         // significand width incl. hidden bit
   localparam int QW = FRAC + 3;         // quotient: significand + guard + round
   localparam int RW = SW + 1;           // partial remainder (< 2 * divisor)
   localparam int EW = EXP + 3;          // signed working exponent

   localparam logic [4:0]           LAST_IT = 5'(QW - 1);
   localparam logic signed [EW-1:0] E_TOP   = EW'((1 << EXP) - 1);
   localparam logic signed [EW-1:0] E_ZERO  = '0;
   localparam logic [W-1:0]         QNAN    = {1'b0, {EXP{1'b1}}, 1'b1, {(FRAC-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PREP  = 3'd1,
      DIV   = 3'd2,
      ROUND = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [W-1:0]           a_reg, b_reg;
   logic                   sign_reg;
   logic signed [EW-1:0]   exp_reg;
   logic [SW-1:0]          div_reg;
   logic [RW-1:0]          rem_reg;
   logic [QW-1:0]          quo_reg;
   logic [4:0]             cnt;
   logic                   special_reg;
   logic [W-1:0]           spec_bits_reg;
   logic [4:0]             spec_flags_reg;

   // ---------------------------------------------------------------------
   // Helpers: leading-zero count and subnormal normalisation
   // ---------------------------------------------------------------------
   function automatic logic [EW-1:0] lzc(input logic [SW-1:0] v);
      logic [EW-1:0] n;
      n = EW'(SW);
      // Ascending scan: the highest set bit is the last to overwrite n.
      for (int i = 0; i < SW; i++) begin
         if (v[i]) n = EW'(SW - 1 - i);
      end
      return n;
   endfunction

   function automatic logic [SW-1:0] norm_sig(input logic [EXP-1:0] e, input logic [FRAC-1:0] f);
      logic [SW-1:0] s;
      if (e == '0) begin
         s = {1'b0, f};
         s = s << lzc(s);
      end else begin
         s = {1'b1, f};
      end
      return s;
   endfunction

   // Subnormals behave as exponent 1, minus the shift applied to the fraction.
   function automatic logic signed [EW-1:0] norm_exp(input logic [EXP-1:0] e, input logic [FRAC-1:0] f);
      logic signed [EW-1:0] x;
      if (e == '0) x = EW'(1) - lzc({1'b0, f});
      else         x = {{(EW-EXP){1'b0}}, e};
      return x;
   endfunction

   // ---------------------------------------------------------------------
   // Operand classification (from registered operands)
   // ---------------------------------------------------------------------
   logic [EXP-1:0]  a_exp, b_exp;
   logic [FRAC-1:0] a_frac, b_frac;
   logic            a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
   logic            res_sign;

   assign a_exp    = a_reg[W-2:FRAC];
   assign b_exp    = b_reg[W-2:FRAC];
   assign a_frac   = a_reg[FRAC-1:0];
   assign b_frac   = b_reg[FRAC-1:0];
   assign res_sign = a_reg[W-1] ^ b_reg[W-1];

   assign a_nan  = (&a_exp) && (a_frac != '0);
   assign b_nan  = (&b_exp) && (b_frac != '0);
   assign a_snan = a_nan && !a_frac[FRAC-1];
   assign b_snan = b_nan && !b_frac[FRAC-1];
   assign a_inf  = (&a_exp) && (a_frac == '0);
   assign b_inf  = (&b_exp) && (b_frac == '0);
   assign a_zero = (a_exp == '0) && (a_frac == '0);
   assign b_zero = (b_exp == '0) && (b_frac == '0);

   logic           is_special;
   logic [W-1:0]   sp_bits;
   logic [4:0]     sp_flags;

   always_comb begin
      is_special = 1'b1;
      sp_bits    = QNAN;
      sp_flags   = '0;
      if (a_nan || b_nan) begin
         sp_flags[`F_INVALID] = a_snan || b_snan;
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
         sp_flags[`F_INVALID] = 1'b1;
      end else if (a_inf) begin
         sp_bits = {res_sign, {EXP{1'b1}}, {FRAC{1'b0}}};
      end else if (b_zero) begin
         sp_bits                     = {res_sign, {EXP{1'b1}}, {FRAC{1'b0}}};
         sp_flags[`F_DIVIDE_BY_ZERO] = 1'b1;
      end else if (b_inf || a_zero) begin
         sp_bits = {res_sign, {(W-1){1'b0}}};
      end else begin
         is_special = 1'b0;
      end
   end

   logic [SW-1:0]        sig_a, sig_b;
   logic signed [EW-1:0] exp_diff;

   always_comb begin
      sig_a    = norm_sig(a_exp, a_frac);
      sig_b    = norm_sig(b_exp, b_frac);
      exp_diff = norm_exp(a_exp, a_frac) - norm_exp(b_exp, b_frac) + EW'(BIAS);
   end

   // ---------------------------------------------------------------------
   // Division step
   // ---------------------------------------------------------------------
   logic          rem_ge;
   logic [RW-1:0] rem_diff;

   assign rem_ge   = rem_reg >= {1'b0, div_reg};
   assign rem_diff = rem_reg - {1'b0, div_reg};

   // ---------------------------------------------------------------------
   // Normalise / round / range check
   // ---------------------------------------------------------------------
   logic [SW-1:0]        mant_sel;
   logic                 g_bit, r_bit, s_bit, inc;
   logic [SW:0]          sum;
   logic [FRAC-1:0]      frac_fin;
   logic signed [EW-1:0] e_adj, e_fin;
   logic [W-1:0]         rnd_bits;
   logic [4:0]           rnd_flags;

   always_comb begin
      // Quotient lies in (0.5, 2); a clear top bit needs one left shift.
      // The bit shifted into the round position is 0; any lost weight is
      // still represented by the non-zero remainder (sticky).
      if (quo_reg[QW-1]) begin
         mant_sel = quo_reg[QW-1:2];
         g_bit    = quo_reg[1];
         r_bit    = quo_reg[0];
         e_adj    = exp_reg;
      end else begin
         mant_sel = quo_reg[QW-2:1];
         g_bit    = quo_reg[0];
         r_bit    = 1'b0;
         e_adj    = exp_reg - EW'(1);
      end
      s_bit = rem_reg != '0;

`ifdef FP_DIV_ROUND_NEAREST_EN
      inc = g_bit && (r_bit || s_bit || mant_sel[0]);
`else
      inc = 1'b0;
`endif

      sum = {1'b0, mant_sel} + {{SW{1'b0}}, inc};
      if (sum[SW]) begin
         frac_fin = sum[FRAC:1];
         e_fin    = e_adj + EW'(1);
      end else begin
         frac_fin = sum[FRAC-1:0];
         e_fin    = e_adj;
      end

      rnd_flags = '0;
      if (e_fin >= E_TOP) begin
         rnd_bits                = {sign_reg, {EXP{1'b1}}, {FRAC{1'b0}}};
         rnd_flags[`F_OVERFLOW]  = 1'b1;
         rnd_flags[`F_INEXACT]   = 1'b1;
      end else if (e_fin <= E_ZERO) begin
         rnd_bits                = {sign_reg, {(W-1){1'b0}}};
         rnd_flags[`F_UNDERFLOW] = 1'b1;
         rnd_flags[`F_INEXACT]   = 1'b1;
      end else begin
         rnd_bits              = {sign_reg, e_fin[EXP-1:0], frac_fin};
         rnd_flags[`F_INEXACT] = g_bit || r_bit || s_bit;
      end
   end

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Special results take one pass through ROUND so every result is
   // loaded into the output register at the same point.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = PREP;
         end
         PREP:  state_nxt = is_special ? ROUND : DIV;
         DIV:   if (cnt == LAST_IT) state_nxt = ROUND;
         ROUND: state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg          <= '0;
         b_reg          <= '0;
         sign_reg       <= 1'b0;
         exp_reg        <= '0;
         div_reg        <= '0;
         rem_reg        <= '0;
         quo_reg        <= '0;
         cnt            <= '0;
         special_reg    <= 1'b0;
         spec_bits_reg  <= '0;
         spec_flags_reg <= '0;
         out_bits       <= '0;
         except_flags   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a_bits;
                  b_reg <= b_bits;
               end
            end
            PREP: begin
               sign_reg       <= res_sign;
               exp_reg        <= exp_diff;
               div_reg        <= sig_b;
               rem_reg        <= {1'b0, sig_a};
               quo_reg        <= '0;
               cnt            <= '0;
               special_reg    <= is_special;
               spec_bits_reg  <= sp_bits;
               spec_flags_reg <= sp_flags;
            end
            DIV: begin
               if (rem_ge) begin
                  rem_reg <= rem_diff << 1;
                  quo_reg <= {quo_reg[QW-2:0], 1'b1};
               end else begin
                  rem_reg <= rem_reg << 1;
                  quo_reg <= {quo_reg[QW-2:0], 1'b0};
               end
               cnt <= cnt + 5'd1;
            end
            ROUND: begin
               out_bits     <= special_reg ? spec_bits_reg  : rnd_bits;
               except_flags <= special_reg ? spec_flags_reg : rnd_flags;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fp_divider_seq.sv
// ============================================================================
//  Module   : tb_fp_divider_seq
//  Purpose  : Self-checking bench for fp_divider_seq. A driver issues
//             directed and random operand pairs and pushes the expected
//             response into a scoreboard queue; a monitor pops and compares
//             whenever the divider presents a result.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef F_INVALID
`define F_INVALID        4
`endif
`ifndef F_DIVIDE_BY_ZERO
`define F_DIVIDE_BY_ZERO 3
`endif
`ifndef F_OVERFLOW
`define F_OVERFLOW       2
`endif
`ifndef F_UNDERFLOW
`define F_UNDERFLOW      1
`endif
`ifndef F_INEXACT
`define F_INEXACT        0
`endif

module tb_fp_divider_seq;

   localparam logic [4:0] FL_NV = 5'(1 << `F_INVALID);
   localparam logic [4:0] FL_DZ = 5'(1 << `F_DIVIDE_BY_ZERO);
   localparam logic [4:0] FL_OF = 5'(1 << `F_OVERFLOW);
   localparam logic [4:0] FL_UF = 5'(1 << `F_UNDERFLOW);
   localparam logic [4:0] FL_NX = 5'(1 << `F_INEXACT);
   localparam int LAT_NORM = 28;
   localparam int LAT_SPEC = 2;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a_bits, b_bits, out_bits;
   logic [4:0]  except_flags;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   fp_divider_seq dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .a_bits       (a_bits),
      .b_bits       (b_bits),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_bits     (out_bits),
      .except_flags (except_flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] bits;
      logic [4:0]  flags;
      int          lat;
      int          hold;
      int          acc;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   exp_t sb[$];
   bit   mon_busy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: exact integer quotient with a wide scaled dividend
   // ---------------------------------------------------------------------
   function automatic void unpack(input logic [31:0] x, output longint unsigned m, output int e);
      if (x[30:23] == 8'h00) begin
         m = 64'(x[22:0]);
         e = 1;
         while (m < (64'd1 << 23)) begin
            m = m << 1;
            e = e - 1;
         end
      end else begin
         m = 64'(x[22:0]) | (64'd1 << 23);
         e = int'(x[30:23]);
      end
   endfunction

   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [4:0] f, output int lat);
      logic sr;
      bit   a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
      int   ea, eb, e, sh;
      longint unsigned ma, mb, num, q, rem, rest, half, mant;
      sr     = a[31] ^ b[31];
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      a_snan = a_nan && !a[22];
      b_snan = b_nan && !b[22];
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      a_zero = a[30:0] == 0;
      b_zero = b[30:0] == 0;
      f   = '0;
      lat = LAT_SPEC;
      r   = 32'h7FC00000;
      if (a_nan || b_nan) begin
         if (a_snan || b_snan) f = FL_NV;
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
         f = FL_NV;
      end else if (a_inf) begin
         r = {sr, 8'hFF, 23'h0};
      end else if (b_zero) begin
         r = {sr, 8'hFF, 23'h0};
         f = FL_DZ;
      end else if (b_inf || a_zero) begin
         r = {sr, 31'h0};
      end else begin
         lat = LAT_NORM;
         unpack(a, ma, ea);
         unpack(b, mb, eb);
         num = ma << 38;
         q   = num / mb;
         rem = num % mb;
         if (q >= (64'd1 << 38)) begin e = ea - eb + 127; sh = 15; end
         else                    begin e = ea - eb + 126; sh = 14; end
         mant = q >> sh;
         rest = q & ((64'd1 << sh) - 1);
         half = 64'd1 << (sh - 1);
`ifdef FP_DIV_ROUND_NEAREST_EN
         if (rest > half || (rest == half && (rem != 0 || mant[0]))) mant = mant + 1;
`endif
         if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
         end
         if (e >= 255) begin
            r = {sr, 8'hFF, 23'h0};
            f = FL_OF | FL_NX;
         end else if (e <= 0) begin
            r = {sr, 31'h0};
            f = FL_UF | FL_NX;
         end else begin
            r = {sr, e[7:0], mant[22:0]};
            if (rest != 0 || rem != 0) f = FL_NX;
         end
      end
   endfunction

   function automatic logic [31:0] rnd_op();
      logic        s;
      logic [22:0] fr;
      logic [31:0] x;
      s  = 1'($urandom_range(0, 1));
      fr = 23'($urandom);
      case ($urandom_range(0, 11))
         0:       x = {s, 31'h0};
         1:       x = {s, 8'h00, fr | 23'h1};
         2:       x = {s, 8'hFF, 23'h0};
         3:       x = {s, 8'hFF, 1'b1, fr[21:0]};
         4:       x = {s, 8'hFF, 1'b0, fr[21:0] | 22'h1};
         5:       x = {s, 8'(253 + $urandom_range(0, 1)), fr};
         6:       x = {s, 8'($urandom_range(1, 3)), fr};
         7:       x = {s, 8'd127, fr[22:20], 20'h0};
         default: x = {s, 8'($urandom_range(1, 254)), fr};
      endcase
      return x;
   endfunction

   // ---------------------------------------------------------------------
   // Driver tasks (called at a falling edge, return at a falling edge)
   // ---------------------------------------------------------------------
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ebits,
                       input logic [4:0] eflags, input int lat, input int hold);
      exp_t e;
      int   w;
      w = 0;
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready got 0 required 1");
      end else begin
         a_bits   = a;
         b_bits   = b;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         a_bits   = $urandom;      // must be ignored while busy
         b_bits   = $urandom;
         e.bits  = ebits;
         e.flags = eflags;
         e.lat   = lat;
         e.hold  = hold;
         e.acc   = cyc;
         e.a     = a;
         e.b     = b;
         sb.push_back(e);
         @(negedge clk);
      end
   endtask

   task automatic send_model(input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [31:0] r;
      logic [4:0]  f;
      int          lat;
      ref_div(a, b, r, f, lat);
      send(a, b, r, f, lat, hold);
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while ((sb.size() != 0 || mon_busy) && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (sb.size() != 0 || mon_busy) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: pending got %0d required 0", sb.size());
      end
   endtask

   // ---------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------
   initial begin : monitor
      exp_t cur;
      int   hold;
      bit   releasing;
      out_ready = 1'b0;
      releasing = 1'b0;
      hold      = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_busy  = 1'b0;
            releasing = 1'b0;
            out_ready = 1'b0;
         end else if (releasing) begin
            check("idle_after_accept", 32'({out_valid, in_ready}), 32'b01);
            releasing = 1'b0;
            mon_busy  = 1'b0;
            out_ready = 1'b0;
         end else if (out_valid) begin
            if (!mon_busy) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_out: out_bits got %h required no result", out_bits);
                  hold = 0;
               end else begin
                  cur      = sb.pop_front();
                  mon_busy = 1'b1;
                  hold     = cur.hold;
                  check($sformatf("bits %h/%h", cur.a, cur.b), out_bits, cur.bits);
                  check($sformatf("flags %h/%h", cur.a, cur.b), 32'(except_flags), 32'(cur.flags));
                  check($sformatf("latency %h/%h", cur.a, cur.b), 32'(cyc - cur.acc), 32'(cur.lat));
               end
            end else begin
               check("hold_bits", out_bits, cur.bits);
               check("hold_flags", 32'(except_flags), 32'(cur.flags));
               check("hold_in_ready", 32'(in_ready), 32'd0);
            end
            if (hold > 0) begin
               hold--;
               out_ready = 1'b0;
            end else begin
               out_ready = 1'b1;
               releasing = 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin : driver
      int seen;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a_bits   = '0;
      b_bits   = '0;
      repeat (3) @(negedge clk);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_bits", out_bits, 32'h0);
      check("reset_flags", 32'(except_flags), 32'h0);
      rst_n = 1'b1;

      // Directed cases with hand-derived expectations
      send(32'h40C00000, 32'h40000000, 32'h40400000, 5'h0, LAT_NORM, 0);
`ifdef FP_DIV_ROUND_NEAREST_EN
      send(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, FL_NX, LAT_NORM, 0);
`else
      send(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, FL_NX, LAT_NORM, 0);
`endif
      send(32'h3F800000, 32'h00000000, 32'h7F800000, FL_DZ, LAT_SPEC, 0);
      send(32'h00000000, 32'h00000000, 32'h7FC00000, FL_NV, LAT_SPEC, 1);
      send(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, FL_OF | FL_NX, LAT_NORM, 0);
      send(32'h00800000, 32'h40000000, 32'h00000000, FL_UF | FL_NX, LAT_NORM, 0);
      send(32'h40C00000, 32'h40000000, 32'h40400000, 5'h0, LAT_NORM, 10);
      send(32'hFF800000, 32'h00000000, 32'hFF800000, 5'h0, LAT_SPEC, 0);
      send(32'h7F800001, 32'h3F800000, 32'h7FC00000, FL_NV, LAT_SPEC, 0);
      wait_drain();

      // Abort an in-flight division with reset during DIV
      send(32'h3F800000, 32'h40400000, 32'h0, 5'h0, LAT_NORM, 0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      sb.delete(sb.size() - 1);
      repeat (2) @(negedge clk);
      check("midreset_out_valid", 32'(out_valid), 32'd0);
      check("midreset_out_bits", out_bits, 32'h0);
      rst_n = 1'b1;
      check("release_in_ready", 32'(in_ready), 32'd1);
      send_model(32'h40490FDB, 32'h402DF854, 0);
      seen = 0;
      repeat (26) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      check("no_stale_out", 32'(seen), 32'd0);
      wait_drain();

      // Randomized operands against the reference model
      for (int i = 0; i < 150; i++) begin
         send_model(rnd_op(), rnd_op(), int'($urandom_range(0, 2)));
      end
      wait_drain();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: time got limit required completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
